uart_tx_cfg: RTL

//   Parametrised UART transmitter: configurable data width, parity mode and stop bit count, with an internal TX FIFO.

---
 rtl/uart_tx_if.sv | 39 +++
 rtl/uart_tx_cfg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//   Groups the word-side handshake and the serial/status outputs of
//   uart_tx_cfg into one bundle.
//   master : the word producer (drives uart_tx_valid / uart_tx_din)
//   slave  : the transmitter   (drives ready, serial line and status)
// Signals
//   uart_tx_valid     write request for uart_tx_din
//   uart_tx_din       word to send, bit 0 goes out first
//   uart_tx_ready     FIFO can accept a word
//   uart_tx_dout      serial line, idle high
//   uart_tx_busy      transmitter FSM is not idle
//   uart_tx_done      1-cycle pulse in the last cycle of the final stop bit
//   uart_tx_fifo_cnt  words waiting in the FIFO (excludes word on the wire)
// ---------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  uart_tx_valid;
  logic [DATA_WIDTH-1:0] uart_tx_din;
  logic                  uart_tx_ready;
  logic                  uart_tx_dout;
  logic                  uart_tx_busy;
  logic                  uart_tx_done;
  logic [FCNT_W-1:0]     uart_tx_fifo_cnt;

  modport master (
    output uart_tx_valid, uart_tx_din,
    input  uart_tx_ready, uart_tx_dout, uart_tx_busy, uart_tx_done, uart_tx_fifo_cnt
  );

  modport slave (
    input  uart_tx_valid, uart_tx_din,
    output uart_tx_ready, uart_tx_dout, uart_tx_busy, uart_tx_done, uart_tx_fifo_cnt
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Parametrised UART transmitter with an internal TX FIFO. Words enter via
//   a valid/ready handshake and are serialised LSB first as
//   start / data / optional parity / stop bits. Queued frames follow each
//   other with no idle gap.
// Ports
//   sys_clk  system clock, everything on the rising edge
//   reset    synchronous, active-high; aborts any frame and flushes the FIFO
//   tx       uart_tx_if.slave bundle (handshake, serial line, status)
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int SYS_CLK_FREQ = 200_000_000,
  parameter int BAUD_RATE    = 19200,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic     sys_clk,
  input  logic     reset,
  uart_tx_if.slave tx
);
  localparam int BAUD_DIV = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);

  generate
    if (BAUD_DIV < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_cfg: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic                  fifo_ready;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  head_par;

  assign fifo_ready = (fifo_cnt != FCNT_W'(FIFO_DEPTH));
  assign push       = tx.uart_tx_valid && fifo_ready;
  assign fifo_head  = fifo_mem[rd_ptr];
  // Parity is taken from the word as it leaves the FIFO, so later writes
  // can never disturb a frame already in flight.
  assign head_par   = (PARITY_MODE == 2) ? ~(^fifo_head) : (^fifo_head);

  // NOTE: storage array has no reset; only pointers and count define validity.
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr] <= tx.uart_tx_din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;  // idle or push+pop together
      endcase
    end
  end

  // ---------------- Transmit FSM ----------------
  state_t                state_q, state_nx;
  logic [CNT_W-1:0]      baud_q, baud_nx;
  logic [3:0]            idx_q, idx_nx;     // data bit / stop bit index
  logic [DATA_WIDTH-1:0] shift_q, shift_nx;
  logic                  par_q, par_nx;
  logic                  dout_q, dout_nx;
  logic                  bit_end;
  logic                  load;
  logic                  done;

  assign bit_end = (baud_q == CNT_W'(BAUD_DIV - 1));

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state_q;
    baud_nx  = baud_q + CNT_W'(1);
    idx_nx   = idx_q;
    shift_nx = shift_q;
    par_nx   = par_q;
    dout_nx  = dout_q;
    load     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_nx = '0;
        dout_nx = 1'b1;
        if (fifo_cnt != '0) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          baud_nx  = '0;
          idx_nx   = '0;
          dout_nx  = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nx = '0;
          if (idx_q == 4'(DATA_WIDTH - 1)) begin
            if (PARITY_MODE != 0) begin
              state_nx = S_PARITY;
              dout_nx  = par_q;
            end else begin
              state_nx = S_STOP;
              idx_nx   = '0;
              dout_nx  = 1'b1;
            end
          end else begin
            idx_nx   = idx_q + 4'd1;
            shift_nx = {1'b0, shift_q[DATA_WIDTH-1:1]};
            dout_nx  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nx = S_STOP;
          baud_nx  = '0;
          idx_nx   = '0;
          dout_nx  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_nx = '0;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            done = 1'b1;
            // Queued word: chain straight into the next start bit.
            if (fifo_cnt != '0) begin
              load = 1'b1;
            end else begin
              state_nx = S_IDLE;
              dout_nx  = 1'b1;
            end
          end else begin
            idx_nx = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        dout_nx  = 1'b1;
      end
    endcase

    if (load) begin
      state_nx = S_START;
      baud_nx  = '0;
      shift_nx = fifo_head;
      par_nx   = head_par;
      dout_nx  = 1'b0;
    end
  end

  assign pop = load;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_nx;
      baud_q  <= baud_nx;
      idx_q   <= idx_nx;
      shift_q <= shift_nx;
      par_q   <= par_nx;
      dout_q  <= dout_nx;
    end
  end

  assign tx.uart_tx_ready    = fifo_ready;
  assign tx.uart_tx_dout     = dout_q;
  assign tx.uart_tx_busy     = (state_q != S_IDLE);
  assign tx.uart_tx_done     = done;
  assign tx.uart_tx_fifo_cnt = fifo_cnt;
endmodule
